lockstep_step_scheduler: RTL and testbench

//  Sequences one-instruction steps of the DUT core and the reference model in lockstep inside the formal top.

---
 rtl/lockstep_step_scheduler.sv | 106 ++++++++++
 tb/tb_lockstep_step_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_step_scheduler.sv
// Issues one solver-chosen instruction to the DUT core and the reference model together,
// waits for both to retire, then strobes the checker; flags hung cores and protocol abuse.
module lockstep_step_scheduler #(
    parameter int MAX_STALL = 3,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 16,
    parameter int INST_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              rand_stall,
    input  logic              rand_valid,
    input  logic [INST_W-1:0] rand_inst,
    output logic              dut_stall,
    output logic              dut_valid,
    output logic [INST_W-1:0] dut_inst,
    output logic              ref_valid,
    output logic [INST_W-1:0] ref_inst,
    input  logic              dut_done,
    input  logic              ref_done,
    output logic              cmp_valid,
    output logic [CNT_W-1:0]  step_count,
    output logic              timeout,
    output logic              proto_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, HALT} state_t;

    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   wait_tmr;
    logic [INST_W-1:0]  inst_q;
    logic               d_f, r_f;
    logic               both_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Stall is forced low once it has been high MAX_STALL cycles in a row.
    assign dut_stall = !reset && (state != HALT) && rand_stall && (stall_cnt < STALL_LIM);
    assign dut_valid = (state == ISSUE);
    assign ref_valid = (state == ISSUE);
    assign cmp_valid = (state == CMP);
    assign dut_inst  = inst_q;
    assign ref_inst  = inst_q;
    assign both_done = (d_f || dut_done) && (r_f || ref_done);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && rand_valid && !dut_stall) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (both_done)                  state_nxt = CMP;
                else if (wait_tmr == WAIT_LAST) state_nxt = HALT;
            end
            CMP:     state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            stall_cnt  <= '0;
            wait_tmr   <= '0;
            inst_q     <= '0;
            d_f        <= 1'b0;
            r_f        <= 1'b0;
            step_count <= '0;
            timeout    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= dut_stall ? stall_cnt + 1'b1 : '0;
            if (state == IDLE && state_nxt == ISSUE) inst_q <= rand_inst;
            case (state)
                ISSUE: begin
                    wait_tmr <= '0;
                    d_f      <= 1'b0;
                    r_f      <= 1'b0;
                end
                WAIT: begin
                    if (dut_done) d_f <= 1'b1;
                    if (ref_done) r_f <= 1'b1;
                    // A second retire from the same side within one step is a protocol error.
                    if ((dut_done && d_f) || (ref_done && r_f)) proto_err <= 1'b1;
                    if (!both_done) begin
                        wait_tmr <= wait_tmr + 1'b1;
                        if (wait_tmr == WAIT_LAST) timeout <= 1'b1;
                    end
                end
                CMP:     step_count <= sat_inc(step_count);
                default: ;
            endcase
            if (state != WAIT && (dut_done || ref_done)) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lockstep_step_scheduler.sv
// Scoreboard bench for lockstep_step_scheduler: issued instructions and compare counts are
// queued when stimulus is driven and checked when the DUT strobes dut_valid / cmp_valid.
module tb_lockstep_step_scheduler;

    localparam int CW      = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          rand_stall = 1'b0;
    logic          rand_valid = 1'b0;
    logic [31:0]   rand_inst = '0;
    logic          dut_stall, dut_valid, ref_valid, cmp_valid, timeout, proto_err;
    logic [31:0]   dut_inst, ref_inst;
    logic          dut_done = 1'b0;
    logic          ref_done = 1'b0;
    logic [CW-1:0] step_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_steps = 0;
    logic [31:0] exp_inst_q[$];
    int          exp_cmp_q[$];

    lockstep_step_scheduler #(
        .MAX_STALL(3), .TIMEOUT(16), .CNT_W(CW), .INST_W(32)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .rand_stall(rand_stall),
        .rand_valid(rand_valid), .rand_inst(rand_inst), .dut_stall(dut_stall),
        .dut_valid(dut_valid), .dut_inst(dut_inst), .ref_valid(ref_valid),
        .ref_inst(ref_inst), .dut_done(dut_done), .ref_done(ref_done),
        .cmp_valid(cmp_valid), .step_count(step_count), .timeout(timeout),
        .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: compare strobes against what the stimulus queued.
    always @(negedge clock) begin
        if (dut_valid || ref_valid) begin
            chk_eq("issue_both", {dut_valid, ref_valid}, 2'b11);
            if (exp_inst_q.size() == 0) chk_eq("issue_unexp", 1, 0);
            else begin
                logic [31:0] e;
                e = exp_inst_q.pop_front();
                chk_eq("dut_inst", dut_inst, e);
                chk_eq("ref_inst", ref_inst, e);
            end
        end
        if (cmp_valid) begin
            if (exp_cmp_q.size() == 0) chk_eq("cmp_unexp", 1, 0);
            else chk_eq("cmp_count", step_count, exp_cmp_q.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic all_zero_check(input string tag);
        chk_eq(tag, {dut_stall, dut_valid, ref_valid, cmp_valid, timeout, proto_err,
                     dut_inst, ref_inst, 3'b000, step_count}, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; rand_valid = 1'b0; rand_stall = 1'b1;
        dut_done = 1'b0; ref_done = 1'b0;
        cyc(); cyc();
        #1 all_zero_check("reset_outputs");
        exp_steps = 0;
        rand_stall = 1'b0;
        reset = 1'b0;
    endtask

    // Issue from IDLE, retire sides on given WAIT cycles (1-based, 0 = never), expect one compare.
    task automatic run_step(input logic [31:0] inst, input int d_at, input int r_at, input int d2_at);
        int last;
        last = (d_at > r_at) ? d_at : r_at;
        if (d2_at > last) last = d2_at;
        enable = 1'b1; rand_valid = 1'b1; rand_inst = inst; rand_stall = 1'b0;
        exp_inst_q.push_back(inst);
        exp_cmp_q.push_back(exp_steps);
        if (exp_steps < CNT_MAX) exp_steps++;
        cyc();
        rand_valid = 1'b0;
        #1 chk_eq("issue_strobe", dut_valid, 1);
        cyc();
        for (int w = 1; w <= last; w++) begin
            dut_done = (w == d_at) || (w == d2_at);
            ref_done = (w == r_at);
            #1 chk_eq("cmp_early", cmp_valid, 0);
            cyc();
        end
        dut_done = 1'b0; ref_done = 1'b0;
        #1 chk_eq("cmp_strobe", cmp_valid, 1);
        chk_eq("inst_hold", dut_inst, inst);
        cyc();
        #1 chk_eq("cmp_once", cmp_valid, 0);
        chk_eq("step_count", step_count, exp_steps);
    endtask

    initial begin
        int pat[8];
        pat = '{1, 1, 1, 0, 1, 1, 1, 0};

        // Minimum-length step.
        do_reset();
        run_step(32'h0010_0093, 1, 1, 0);
        chk_eq("t1_proto", proto_err, 0);

        // Stall fairness with rand_stall held high; issue lands on the first forced-low cycle.
        exp_inst_q.push_back(32'h0000_0513);
        enable = 1'b1; rand_valid = 1'b1; rand_inst = 32'h0000_0513; rand_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk_eq("stall_pat", dut_stall, pat[i]);
            if (i < 4) chk_eq("stall_no_issue", dut_valid, 0);
            if (i == 4) chk_eq("stall_issue", dut_valid, 1);
            cyc();
        end
        rand_stall = 1'b0; rand_valid = 1'b0; dut_done = 1'b1; ref_done = 1'b1;
        exp_cmp_q.push_back(exp_steps);
        exp_steps++;
        cyc();
        dut_done = 1'b0; ref_done = 1'b0;
        #1 chk_eq("t2_cmp", cmp_valid, 1);
        cyc();
        #1 chk_eq("t2_count", step_count, exp_steps);

        // Sides retire far apart.
        run_step(32'h0020_8133, 1, 5, 0);
        chk_eq("t3_proto", proto_err, 0);

        // Hung reference: timeout after 16 WAIT cycles, then HALT blocks everything.
        exp_inst_q.push_back(32'h00C0_006F);
        enable = 1'b1; rand_valid = 1'b1; rand_inst = 32'h00C0_006F;
        cyc();
        rand_valid = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            if (k <= 15) #1 chk_eq("t4_no_timeout", timeout, 0);
            if (k == 17) #1 chk_eq("t4_timeout", timeout, 1);
        end
        rand_valid = 1'b1; rand_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk_eq("halt_quiet", {dut_valid, dut_stall, cmp_valid, timeout}, 4'b0001);
            cyc();
        end
        chk_eq("t4_proto", proto_err, 0);

        // Retire pulse in IDLE, then a doubled retire inside WAIT.
        do_reset();
        enable = 1'b0; dut_done = 1'b1;
        cyc();
        dut_done = 1'b0;
        #1 chk_eq("t5_idle_proto", proto_err, 1);
        chk_eq("t5_no_cmp", cmp_valid, 0);
        cyc();
        do_reset();
        chk_eq("t5_proto_cleared", proto_err, 0);
        run_step(32'h4000_0033, 1, 3, 2);
        chk_eq("t5_double_proto", proto_err, 1);

        // Reset in the middle of WAIT, then a fresh step.
        do_reset();
        exp_inst_q.push_back(32'h0041_0113);
        enable = 1'b1; rand_valid = 1'b1; rand_inst = 32'h0041_0113;
        cyc();
        rand_valid = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; enable = 1'b0;
        #1 all_zero_check("t6_after_reset");
        exp_steps = 0;
        run_step(32'h0041_0113, 2, 2, 0);
        chk_eq("t6_count", step_count, 1);

        // Drive step_count into saturation.
        for (int s = 0; s < CNT_MAX + 1; s++) run_step(32'h1000_0000 + s, 1, 1, 0);
        chk_eq("sat_count", step_count, CNT_MAX);

        cyc();
        chk_eq("sb_inst_empty", exp_inst_q.size(), 0);
        chk_eq("sb_cmp_empty", exp_cmp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
